cmn_regfile_wr_arbiter: RTL

Merges two independent val/rdy write-request streams into the single write port of a `cmn_Regfile_1r1w`/`cmn_Regfile_2r1w` register file. It is the writer side of the register file: each requester gets a one-entry buffer, arbitration is oldest-first, and the write port is driven from registered outputs. A pending-write mask lets read-side logic detect entries that have an outstanding uncommitted write.

---
 rtl/cmn_regfile_wr_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cmn_regfile_wr_arbiter.sv
// Merges two val/rdy write-request streams into one registered register-file write port.
// Each requester has a one-entry buffer; arbitration is oldest-first with round-robin tie-break.
module cmn_regfile_wr_arbiter #(
  parameter  int p_data_nbits  = 32,
  parameter  int p_num_entries = 32,
  localparam int c_addr_nbits  = $clog2(p_num_entries)
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req0_val,
  output logic                     req0_rdy,
  input  logic [c_addr_nbits-1:0]  req0_addr,
  input  logic [p_data_nbits-1:0]  req0_data,

  input  logic                     req1_val,
  output logic                     req1_rdy,
  input  logic [c_addr_nbits-1:0]  req1_addr,
  input  logic [p_data_nbits-1:0]  req1_data,

  output logic                     write_en,
  output logic [c_addr_nbits-1:0]  write_addr,
  output logic [p_data_nbits-1:0]  write_data,

  output logic [p_num_entries-1:0] pend_mask
);

  localparam logic [c_addr_nbits:0] c_num_entries = (c_addr_nbits + 1)'(p_num_entries);

  function automatic logic addr_in_range(input logic [c_addr_nbits-1:0] addr);
    return {1'b0, addr} < c_num_entries;
  endfunction

  // Buffer state
  logic                    buf0_val, buf1_val;
  logic [c_addr_nbits-1:0] buf0_addr, buf1_addr;
  logic [p_data_nbits-1:0] buf0_data, buf1_data;

  // Age state: tie_q means both occupied buffers were loaded on the same edge,
  // otherwise old1_q says buffer 1 holds the older request.
  logic tie_q, tie_d;
  logic old1_q, old1_d;
  logic rr_q;

  logic write_en_q;

  logic grant0, grant1, grant_any, tie_grant;
  logic xfer0, xfer1;
  logic nxt0_val, nxt1_val;
  logic [c_addr_nbits-1:0] grant_addr;
  logic [p_data_nbits-1:0] grant_data;
  logic [p_num_entries-1:0] pend_raw;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    tie_grant = 1'b0;
    if (buf0_val && buf1_val) begin
      if (tie_q) begin
        tie_grant = 1'b1;
        grant0    = !rr_q;
        grant1    = rr_q;
      end else begin
        grant0 = !old1_q;
        grant1 = old1_q;
      end
    end else if (buf0_val) begin
      grant0 = 1'b1;
    end else if (buf1_val) begin
      grant1 = 1'b1;
    end
  end

  assign grant_any  = grant0 || grant1;
  assign grant_addr = grant1 ? buf1_addr : buf0_addr;
  assign grant_data = grant1 ? buf1_data : buf0_data;

  // A buffer being drained this cycle can accept a new request on the same edge.
  assign req0_rdy = reset && (!buf0_val || grant0);
  assign req1_rdy = reset && (!buf1_val || grant1);

  assign xfer0 = req0_val && req0_rdy;
  assign xfer1 = req1_val && req1_rdy;

  assign nxt0_val = xfer0 || (buf0_val && !grant0);
  assign nxt1_val = xfer1 || (buf1_val && !grant1);

  always_comb begin
    tie_d  = tie_q;
    old1_d = old1_q;
    if (nxt0_val && nxt1_val) begin
      if (xfer0 && xfer1) begin
        tie_d = 1'b1;
      end else if (xfer0) begin
        tie_d  = 1'b0;
        old1_d = 1'b1;
      end else if (xfer1) begin
        tie_d  = 1'b0;
        old1_d = 1'b0;
      end
    end else begin
      tie_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf0_val   <= 1'b0;
      buf1_val   <= 1'b0;
      tie_q      <= 1'b0;
      old1_q     <= 1'b0;
      rr_q       <= 1'b0;
      write_en_q <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      buf0_val <= nxt0_val;
      buf1_val <= nxt1_val;
      tie_q    <= tie_d;
      old1_q   <= old1_d;
      if (tie_grant) rr_q <= !rr_q;
      // Out-of-range requests are consumed here without ever reaching the write port.
      write_en_q <= grant_any && addr_in_range(grant_addr);
      if (grant_any && addr_in_range(grant_addr)) begin
        write_addr <= grant_addr;
        write_data <= grant_data;
      end
    end
  end

  // NOTE: buffer payloads are qualified by their valid bits, so they carry no reset and cost
  // no reset routing.
  always_ff @(posedge clk) begin
    if (xfer0) begin
      buf0_addr <= req0_addr;
      buf0_data <= req0_data;
    end
    if (xfer1) begin
      buf1_addr <= req1_addr;
      buf1_data <= req1_data;
    end
  end

  always_comb begin
    pend_raw = '0;
    if (buf0_val && addr_in_range(buf0_addr)) pend_raw[buf0_addr] = 1'b1;
    if (buf1_val && addr_in_range(buf1_addr)) pend_raw[buf1_addr] = 1'b1;
    if (write_en_q)                           pend_raw[write_addr] = 1'b1;
  end

  // The write port and mask are forced quiet while reset is held, so a write sitting in the
  // output stage is never committed on the reset edge.
  assign write_en  = write_en_q && reset;
  assign pend_mask = reset ? pend_raw : '0;

endmodule
